// File: rtl/dpram.sv
// True dual-port synchronous RAM shared by two requesters, one clock, valid/ready per port.
// On a same-address double write, port A wins and port B is stalled until the collision clears.
module dpram #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  we_a,
    input  logic                  valid_a,
    output logic                  ready_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  we_b,
    input  logic                  valid_b,
    output logic                  ready_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  collide;
    logic                  acc_a;
    logic                  acc_b;

    always_comb begin
        collide = valid_a && valid_b && we_a && we_b && (addr_a == addr_b);
        ready_a = rst_n;
        ready_b = rst_n && !collide;
        acc_a   = valid_a && ready_a;
        acc_b   = valid_b && ready_b;
    end

    // Writes land at the edge; both ports can never write the same word together,
    // since a collision removes B's ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (acc_a && we_a) begin
                mem[addr_a] <= data_a;
            end
            if (acc_b && we_b) begin
                mem[addr_b] <= data_b;
            end
        end
    end

    // Reads sample the pre-edge contents, giving read-before-write across ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (acc_a && !we_a) begin
                q_a <= mem[addr_a];
            end
            if (acc_b && !we_b) begin
                q_b <= mem[addr_b];
            end
        end
    end

endmodule

// File: tb/tb_dpram.sv
// Directed table-driven bench for dpram, plus hand sequences for idle hold and mid-run reset.
module tb_dpram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] addr_a, addr_b;
    logic [7:0] data_a, data_b;
    logic       we_a, we_b, valid_a, valid_b;
    logic       ready_a, ready_b;
    logic [7:0] q_a, q_b;

    int n_vec  = 0;
    int n_fail = 0;

    dpram #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .valid_a(valid_a),
        .ready_a(ready_a), .q_a(q_a),
        .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .valid_b(valid_b),
        .ready_b(ready_b), .q_b(q_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       va, wa;
        logic [5:0] aa;
        logic [7:0] da;
        logic       vb, wb;
        logic [5:0] ab;
        logic [7:0] db;
        logic       exp_rb;
        logic [7:0] exp_qa, exp_qb;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic va, logic wa, logic [5:0] aa, logic [7:0] da,
                                logic vb, logic wb, logic [5:0] ab, logic [7:0] db,
                                logic rb, logic [7:0] qa, logic [7:0] qb);
        vec_t v;
        v.va = va; v.wa = wa; v.aa = aa; v.da = da;
        v.vb = vb; v.wb = wb; v.ab = ab; v.db = db;
        v.exp_rb = rb; v.exp_qa = qa; v.exp_qb = qb;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic va, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                         input logic vb, input logic wb, input logic [5:0] ab, input logic [7:0] db);
        valid_a = va; we_a = wa; addr_a = aa; data_a = da;
        valid_b = vb; we_b = wb; addr_b = ab; data_b = db;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00);

        //   va wa  aa     da     vb wb  ab     db     rb  qa     qb
        add(1, 1, 6'h10, 8'hA5, 0, 0, 6'h00, 8'h00, 1, 8'h00, 8'h00);
        add(1, 0, 6'h10, 8'h00, 0, 0, 6'h00, 8'h00, 1, 8'hA5, 8'h00);
        add(1, 1, 6'h05, 8'h3C, 0, 0, 6'h00, 8'h00, 1, 8'hA5, 8'h00);
        add(0, 0, 6'h00, 8'h00, 1, 0, 6'h05, 8'h00, 1, 8'hA5, 8'h3C);
        add(0, 0, 6'h00, 8'h00, 1, 1, 6'h3F, 8'h77, 1, 8'hA5, 8'h3C);
        add(1, 0, 6'h3F, 8'h00, 0, 0, 6'h00, 8'h00, 1, 8'h77, 8'h3C);
        add(1, 1, 6'h08, 8'h11, 1, 1, 6'h08, 8'h22, 0, 8'h77, 8'h3C);
        add(1, 0, 6'h08, 8'h00, 1, 1, 6'h08, 8'h22, 1, 8'h11, 8'h3C);
        add(0, 0, 6'h00, 8'h00, 1, 0, 6'h08, 8'h00, 1, 8'h11, 8'h22);
        add(1, 1, 6'h20, 8'h01, 0, 0, 6'h00, 8'h00, 1, 8'h11, 8'h22);
        add(1, 1, 6'h20, 8'hFF, 1, 0, 6'h20, 8'h00, 1, 8'h11, 8'h01);
        add(0, 0, 6'h00, 8'h00, 1, 0, 6'h20, 8'h00, 1, 8'h11, 8'hFF);
        add(0, 1, 6'h20, 8'h99, 0, 0, 6'h00, 8'h00, 1, 8'h11, 8'hFF);
        add(0, 0, 6'h00, 8'h00, 1, 0, 6'h20, 8'h00, 1, 8'h11, 8'hFF);
        add(1, 0, 6'h10, 8'h00, 1, 0, 6'h10, 8'h00, 1, 8'hA5, 8'hA5);
        add(1, 1, 6'h2A, 8'hC3, 1, 1, 6'h15, 8'h3D, 1, 8'hA5, 8'hA5);
        add(1, 0, 6'h15, 8'h00, 1, 0, 6'h2A, 8'h00, 1, 8'h3D, 8'hC3);
        add(0, 1, 6'h30, 8'h55, 1, 1, 6'h30, 8'h44, 1, 8'h3D, 8'hC3);
        add(1, 0, 6'h30, 8'h00, 1, 0, 6'h3F, 8'h00, 1, 8'h44, 8'h77);

        repeat (2) @(posedge clk);
        #1;
        chk("reset q_a", q_a, 8'h00);
        chk("reset q_b", q_b, 8'h00);
        chk("reset ready_a", {7'b0, ready_a}, 8'h00);
        chk("reset ready_b", {7'b0, ready_b}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].va, vecs[i].wa, vecs[i].aa, vecs[i].da,
                  vecs[i].vb, vecs[i].wb, vecs[i].ab, vecs[i].db);
            #1;
            chk($sformatf("v%0d ready_a", i), {7'b0, ready_a}, 8'h01);
            chk($sformatf("v%0d ready_b", i), {7'b0, ready_b}, {7'b0, vecs[i].exp_rb});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d q_a", i), q_a, vecs[i].exp_qa);
            chk($sformatf("v%0d q_b", i), q_b, vecs[i].exp_qb);
        end

        // Idle with write enable and data asserted but valid low: q_a holds, memory untouched.
        @(negedge clk);
        drive(0, 1, 6'h30, 8'h99, 0, 1, 6'h3F, 8'h99);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d q_a", k), q_a, 8'h44);
        end
        @(negedge clk);
        drive(1, 0, 6'h3F, 8'h00, 1, 0, 6'h30, 8'h00);
        @(posedge clk);
        #1;
        chk("idle mem 3F", q_a, 8'h77);
        chk("idle mem 30", q_b, 8'h44);

        // Mid-run reset between edges: outputs clear at once, memory is wiped.
        @(negedge clk);
        drive(1, 1, 6'h02, 8'h5A, 0, 0, 6'h00, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drive(1, 0, 6'h02, 8'h00, 1, 1, 6'h03, 8'hEE);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst q_a", q_a, 8'h00);
        chk("async rst q_b", q_b, 8'h00);
        chk("async rst ready_a", {7'b0, ready_a}, 8'h00);
        chk("async rst ready_b", {7'b0, ready_b}, 8'h00);
        @(posedge clk);
        #1;
        chk("in rst q_a", q_a, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 6'h02, 8'h00, 1, 0, 6'h03, 8'h00);
        @(posedge clk);
        #1;
        chk("post rst mem 02", q_a, 8'h00);
        chk("post rst mem 03", q_b, 8'h00);
        @(negedge clk);
        drive(1, 0, 6'h3F, 8'h00, 1, 0, 6'h10, 8'h00);
        @(posedge clk);
        #1;
        chk("post rst mem 3F", q_a, 8'h00);
        chk("post rst mem 10", q_b, 8'h00);

        @(negedge clk);
        drive(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram.md
Name: dpram

Overview:
- Single-clock, true dual-port synchronous RAM with two independent read/write ports, A and B.
- Each port uses a valid/ready request handshake: the requester drives valid, the RAM drives ready.
- Used as the shared storage block between two requesters; each side connects through one port_if bundle (addr, data, we, q, valid, ready).
- Includes write-collision arbitration (port A wins) and a defined read-during-write policy.

Parameters:
- ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH = 64 words.
- DATA_WIDTH, 8, word width in bits.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- addr_a  input  ADDR_WIDTH  port A word address.
- data_a  input  DATA_WIDTH  port A write data.
- we_a  input  1  port A write enable (1 = write, 0 = read).
- valid_a  input  1  port A request valid.
- ready_a  output  1  port A able to accept the request this cycle.
- q_a  output  DATA_WIDTH  port A registered read data.
- addr_b  input  ADDR_WIDTH  port B word address.
- data_b  input  DATA_WIDTH  port B write data.
- we_b  input  1  port B write enable.
- valid_b  input  1  port B request valid.
- ready_b  output  1  port B able to accept the request this cycle.
- q_b  output  DATA_WIDTH  port B registered read data.

Behaviour:
- Reset, while rst_n = 0, takes effect immediately without waiting for clk:
  - all 64 memory words cleared to 0;
  - q_a = q_b = 0;
  - ready_a = ready_b = 0.
  - No request is accepted during reset.
  - Reset asserted mid-transaction aborts that transaction; nothing is written.
- Ready generation is combinational from inputs and the reset state:
  - ready_a = 1 whenever out of reset.
  - ready_b = 1 whenever out of reset, except in a write collision (defined below), when it is 0.
- A request is accepted on a rising clk edge where valid_x && ready_x = 1. When valid_x = 0, or the request is not accepted, the port is idle: memory unchanged, q_x holds.
- Write, accepted with we_x = 1:
  - mem[addr_x] <= data_x at that edge.
  - q_x holds its previous value.
- Read, accepted with we_x = 0:
  - q_x <= mem[addr_x] at that edge, so data is visible the cycle after acceptance (1-cycle latency).
  - q_x holds until the next accepted read on that port.
  - Back-to-back reads on consecutive cycles are supported at full throughput.
- Write collision: both ports valid, both we = 1, addr_a == addr_b.
  - ready_b = 0; only A's write is performed.
  - B must hold its request; it is accepted on the first later cycle without a collision.
- Writes to different addresses on both ports in the same cycle: both performed, both ready = 1.
- Read-during-write across ports, same address, same cycle: the reading port gets the OLD contents (read-before-write); the write still completes at that edge.
- Both ports reading the same address: both receive the same data; no stall.
- Address arithmetic: no wrap logic is needed. addr is exactly ADDR_WIDTH bits, so every value 0..63 is valid, including 63.
- No X propagation: q_x is always a defined value after reset.

Test Plan:
- Basic write/read, port A: reset; A writes 0xA5 to addr 0x10; next cycle A reads 0x10 → q_a = 0xA5 on the following cycle; q_b stays 0.
- Cross-port: A writes 0x3C to 0x05; B then reads 0x05 → q_b = 0x3C. B writes 0x77 to 0x3F (top address); A reads 0x3F → q_a = 0x77.
- Write collision: A writes 0x11 and B writes 0x22 to 0x08 in the same cycle → ready_b = 0 that cycle; mem[0x08] = 0x11; B's request, still held, is accepted next cycle; a subsequent read returns 0x22.
- Read-during-write: mem[0x20] = 0x01; A writes 0xFF to 0x20 while B reads 0x20 in the same cycle → q_b = 0x01; the next read by B returns 0xFF.
- Reset mid-operation: after writing 0x5A to 0x02, assert rst_n = 0 between clock edges → q_a, q_b, ready_a and ready_b go to 0 immediately; after release, reading 0x02 returns 0x00.
- Idle / hold: valid_a = 0 with we_a = 1 and data_a = 0x99 → memory unchanged. q_a keeps its last read value across 5 idle cycles.
